// File: rtl/uart_word_serializer.sv
// rtl/uart_word_serializer.sv - pops FIFO words and feeds them bytewise to a UART transmitter.
// Optional trailing XOR checksum byte per word when UART_SER_CHECKSUM_EN is defined.
module uart_word_serializer #(
  parameter int DATA_BITS = 32,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_BITS  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_fifo_empty,
  input  logic [DATA_BITS-1:0] i_fifo_data,
  output logic                 o_fifo_rd,
  input  logic                 i_uart_done,
  output logic                 o_uart_start,
  output logic [7:0]           o_uart_data,
  output logic                 o_busy,
  output logic                 o_all_done,
  output logic [CNT_BITS-1:0]  o_word_cnt
);

  localparam int NBYTES   = DATA_BITS / 8;
  localparam int IDX_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [DATA_BITS-1:0]  buffer_q, buffer_d;
  logic [IDX_BITS-1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]            uart_data_q, uart_data_d;
  logic [CNT_BITS-1:0]   word_cnt_q, word_cnt_d;
  logic                  last_byte;
`ifdef UART_SER_CHECKSUM_EN
  logic                  chk_phase_q, chk_phase_d;

  function automatic logic [7:0] word_xor(input logic [DATA_BITS-1:0] w);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < NBYTES; i++) acc = acc ^ w[i*8 +: 8];
    return acc;
  endfunction
`endif

  // Byte position within the word depends on the configured transmit order.
  function automatic logic [7:0] byte_at(input logic [DATA_BITS-1:0] w,
                                         input logic [IDX_BITS-1:0]  idx);
    int pos;
    pos = MSB_FIRST ? (NBYTES - 1 - int'(idx)) : int'(idx);
    return w[pos*8 +: 8];
  endfunction

  assign last_byte = (byte_idx_q == IDX_BITS'(NBYTES - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      buffer_q    <= '0;
      byte_idx_q  <= '0;
      uart_data_q <= '0;
      word_cnt_q  <= '0;
`ifdef UART_SER_CHECKSUM_EN
      chk_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buffer_q    <= buffer_d;
      byte_idx_q  <= byte_idx_d;
      uart_data_q <= uart_data_d;
      word_cnt_q  <= word_cnt_d;
`ifdef UART_SER_CHECKSUM_EN
      chk_phase_q <= chk_phase_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!i_fifo_empty && i_enable) state_d = S_LOAD;
      S_LOAD: state_d = S_SEND;
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (i_uart_done) begin
`ifdef UART_SER_CHECKSUM_EN
          state_d = chk_phase_q ? S_IDLE : S_SEND;
`else
          state_d = last_byte ? S_IDLE : S_SEND;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buffer_d    = buffer_q;
    byte_idx_d  = byte_idx_q;
    uart_data_d = uart_data_q;
    word_cnt_d  = word_cnt_q;
`ifdef UART_SER_CHECKSUM_EN
    chk_phase_d = chk_phase_q;
`endif
    if (state_q == S_LOAD) begin
      buffer_d    = i_fifo_data;
      byte_idx_d  = '0;
      uart_data_d = byte_at(i_fifo_data, '0);
`ifdef UART_SER_CHECKSUM_EN
      chk_phase_d = 1'b0;
`endif
    end else if (state_q == S_WAIT && i_uart_done) begin
`ifdef UART_SER_CHECKSUM_EN
      if (chk_phase_q) begin
        word_cnt_d  = word_cnt_q + 1'b1;
        chk_phase_d = 1'b0;
      end else if (last_byte) begin
        uart_data_d = word_xor(buffer_q);
        chk_phase_d = 1'b1;
      end else begin
        byte_idx_d  = byte_idx_q + 1'b1;
        uart_data_d = byte_at(buffer_q, byte_idx_q + 1'b1);
      end
`else
      if (last_byte) begin
        word_cnt_d  = word_cnt_q + 1'b1;
      end else begin
        byte_idx_d  = byte_idx_q + 1'b1;
        uart_data_d = byte_at(buffer_q, byte_idx_q + 1'b1);
      end
`endif
    end
  end

  always_comb begin
    o_fifo_rd    = (state_q == S_LOAD);
    o_uart_start = (state_q == S_SEND);
    o_busy       = (state_q != S_IDLE);
    o_all_done   = (state_q == S_IDLE) && i_fifo_empty;
  end

  assign o_uart_data = uart_data_q;
  assign o_word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_uart_word_serializer.sv
// tb/tb_uart_word_serializer.sv - directed bench for uart_word_serializer (three parameterisations).
module tb_uart_word_serializer;

`ifdef UART_SER_CHECKSUM_EN
  localparam int CHK = 1;
  logic [7:0] e3 [6] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h44, 8'h77};
`else
  localparam int CHK = 0;
  logic [7:0] e3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
`endif
  localparam int NF32 = 4 + CHK;
  localparam int NF16 = 2 + CHK;

  logic [7:0] e1 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
  logic [7:0] e2 [5] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h00};
  logic [7:0] e4 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- instance A: default parameters
  logic        en_a = 1'b0, rd_p_a, start_a, busy_a, alld_a, done_a = 1'b0, empty_a;
  logic [7:0]  data_a;
  logic [15:0] cnt_a;
  logic [31:0] mem_a [16];
  logic [31:0] head_a;
  logic [7:0]  wr_a = 0, rd_a = 0;
  logic [3:0]  dcnt_a = 0;
  logic [7:0]  log_a [64];
  int          nlog_a = 0;
  assign empty_a = (wr_a == rd_a);
  assign head_a  = mem_a[rd_a[3:0]];

  uart_word_serializer dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_a), .i_fifo_empty(empty_a),
    .i_fifo_data(head_a), .o_fifo_rd(rd_p_a), .i_uart_done(done_a),
    .o_uart_start(start_a), .o_uart_data(data_a), .o_busy(busy_a),
    .o_all_done(alld_a), .o_word_cnt(cnt_a));

  always @(posedge clk) begin
    if (rd_p_a) rd_a <= rd_a + 1;
    if (start_a) begin log_a[nlog_a[5:0]] <= data_a; nlog_a <= nlog_a + 1; end
    if (!rst_n) begin dcnt_a <= 0; done_a <= 1'b0; end
    else begin
      done_a <= (dcnt_a == 4'd1);
      if (start_a) dcnt_a <= 4'd5; else if (dcnt_a != 0) dcnt_a <= dcnt_a - 1;
    end
  end

  // ---------------- instance B: MSB first
  logic        en_b = 1'b0, rd_p_b, start_b, busy_b, alld_b, done_b = 1'b0, empty_b;
  logic [7:0]  data_b;
  logic [15:0] cnt_b;
  logic [31:0] mem_b [16];
  logic [31:0] head_b;
  logic [7:0]  wr_b = 0, rd_b = 0;
  logic [3:0]  dcnt_b = 0;
  logic [7:0]  log_b [64];
  int          nlog_b = 0;
  assign empty_b = (wr_b == rd_b);
  assign head_b  = mem_b[rd_b[3:0]];

  uart_word_serializer #(.MSB_FIRST(1'b1)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_b), .i_fifo_empty(empty_b),
    .i_fifo_data(head_b), .o_fifo_rd(rd_p_b), .i_uart_done(done_b),
    .o_uart_start(start_b), .o_uart_data(data_b), .o_busy(busy_b),
    .o_all_done(alld_b), .o_word_cnt(cnt_b));

  always @(posedge clk) begin
    if (rd_p_b) rd_b <= rd_b + 1;
    if (start_b) begin log_b[nlog_b[5:0]] <= data_b; nlog_b <= nlog_b + 1; end
    if (!rst_n) begin dcnt_b <= 0; done_b <= 1'b0; end
    else begin
      done_b <= (dcnt_b == 4'd1);
      if (start_b) dcnt_b <= 4'd5; else if (dcnt_b != 0) dcnt_b <= dcnt_b - 1;
    end
  end

  // ---------------- instance C: 16-bit words, 2-bit counter
  logic        en_c = 1'b0, rd_p_c, start_c, busy_c, alld_c, done_c = 1'b0, empty_c;
  logic [7:0]  data_c;
  logic [1:0]  cnt_c;
  logic [15:0] mem_c [16];
  logic [15:0] head_c;
  logic [7:0]  wr_c = 0, rd_c = 0;
  logic [3:0]  dcnt_c = 0;
  logic [7:0]  log_c [64];
  int          nlog_c = 0;
  int          idle_run_c = 0, last_idle_c = 0;
  assign empty_c = (wr_c == rd_c);
  assign head_c  = mem_c[rd_c[3:0]];

  uart_word_serializer #(.DATA_BITS(16), .CNT_BITS(2)) dut_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_c), .i_fifo_empty(empty_c),
    .i_fifo_data(head_c), .o_fifo_rd(rd_p_c), .i_uart_done(done_c),
    .o_uart_start(start_c), .o_uart_data(data_c), .o_busy(busy_c),
    .o_all_done(alld_c), .o_word_cnt(cnt_c));

  always @(posedge clk) begin
    if (rd_p_c) rd_c <= rd_c + 1;
    if (start_c) begin log_c[nlog_c[5:0]] <= data_c; nlog_c <= nlog_c + 1; end
    if (busy_c) begin
      if (idle_run_c != 0) last_idle_c <= idle_run_c;
      idle_run_c <= 0;
    end else idle_run_c <= idle_run_c + 1;
    if (!rst_n) begin dcnt_c <= 0; done_c <= 1'b0; end
    else begin
      done_c <= (dcnt_c == 4'd1);
      if (start_c) dcnt_c <= 4'd5; else if (dcnt_c != 0) dcnt_c <= dcnt_c - 1;
    end
  end

  initial begin
    int base;
    logic [7:0] rd_base;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_rd", 32'(rd_p_a), 32'd0);
    check("rst_start", 32'(start_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_all_done", 32'(alld_a), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: default order
    base = nlog_a;
    mem_a[wr_a[3:0]] = 32'hDDCCBBAA; wr_a = wr_a + 1;
    en_a = 1'b1;
    for (int k = 0; k < 400 && !(nlog_a >= base + NF32 && !busy_a); k++) @(negedge clk);
    check("t1_finished", 32'(nlog_a - base), 32'(NF32));
    for (int i = 0; i < NF32; i++) check($sformatf("t1_byte%0d", i), 32'(log_a[base + i]), 32'(e1[i]));
    check("t1_pops", 32'(rd_a), 32'd1);
    check("t1_cnt", 32'(cnt_a), 32'd1);
    check("t1_all_done", 32'(alld_a), 32'd1);

    // T2: MSB first
    base = nlog_b;
    mem_b[wr_b[3:0]] = 32'hDDCCBBAA; wr_b = wr_b + 1;
    en_b = 1'b1;
    for (int k = 0; k < 400 && !(nlog_b >= base + NF32 && !busy_b); k++) @(negedge clk);
    check("t2_finished", 32'(nlog_b - base), 32'(NF32));
    for (int i = 0; i < NF32; i++) check($sformatf("t2_byte%0d", i), 32'(log_b[base + i]), 32'(e2[i]));
    check("t2_cnt", 32'(cnt_b), 32'd1);

    // T3: two 16-bit words back to back
    base = nlog_c;
    mem_c[wr_c[3:0]] = 16'h2211; wr_c = wr_c + 1;
    mem_c[wr_c[3:0]] = 16'h4433; wr_c = wr_c + 1;
    en_c = 1'b1;
    for (int k = 0; k < 400 && !(nlog_c >= base + 2*NF16 && !busy_c); k++) @(negedge clk);
    check("t3_finished", 32'(nlog_c - base), 32'(2*NF16));
    for (int i = 0; i < 2*NF16; i++) check($sformatf("t3_byte%0d", i), 32'(log_c[base + i]), 32'(e3[i]));
    check("t3_pops", 32'(rd_c), 32'd2);
    check("t3_idle_gap", 32'(last_idle_c), 32'd1);
    check("t3_cnt", 32'(cnt_c), 32'd2);

    // counter wrap: 4 words on a 2-bit counter
    base = nlog_c;
    mem_c[wr_c[3:0]] = 16'h6655; wr_c = wr_c + 1;
    mem_c[wr_c[3:0]] = 16'h8877; wr_c = wr_c + 1;
    for (int k = 0; k < 400 && !(nlog_c >= base + 2*NF16 && !busy_c); k++) @(negedge clk);
    check("wrap_finished", 32'(nlog_c - base), 32'(2*NF16));
    check("wrap_cnt", 32'(cnt_c), 32'd0);
    check("wrap_pops", 32'(rd_c), 32'd4);

    // T4: enable gate and start latency
    en_a = 1'b0;
    base = nlog_a;
    rd_base = rd_a;
    mem_a[wr_a[3:0]] = 32'h44332211; wr_a = wr_a + 1;
    repeat (20) @(negedge clk);
    check("t4_no_pop", 32'(rd_a - rd_base), 32'd0);
    check("t4_no_start", 32'(nlog_a - base), 32'd0);
    check("t4_all_done", 32'(alld_a), 32'd0);
    en_a = 1'b1;
    @(negedge clk);
    check("t4_rd_latency", 32'(rd_p_a), 32'd1);
    @(negedge clk);
    check("t4_start_latency", 32'(start_a), 32'd1);
    check("t4_rd_once", 32'(rd_p_a), 32'd0);
    for (int k = 0; k < 400 && !(nlog_a >= base + NF32 && !busy_a); k++) @(negedge clk);
    check("t4_finished", 32'(nlog_a - base), 32'(NF32));
    for (int i = 0; i < NF32; i++) check($sformatf("t4_byte%0d", i), 32'(log_a[base + i]), 32'(e4[i]));
    check("t4_cnt", 32'(cnt_a), 32'd2);

    // T5: reset while waiting for done on the second byte
    base = nlog_a;
    rd_base = rd_a;
    mem_a[wr_a[3:0]] = 32'h88776655; wr_a = wr_a + 1;
    for (int k = 0; k < 200 && nlog_a < base + 2; k++) @(negedge clk);
    check("t5_reached_byte2", 32'(nlog_a - base), 32'd2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    en_a = 1'b0;
    #1;
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_data", 32'(data_a), 32'd0);
    check("t5_cnt", 32'(cnt_a), 32'd0);
    check("t5_start", 32'(start_a), 32'd0);
    check("t5_rd", 32'(rd_p_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_more_start", 32'(nlog_a - base), 32'd2);
    check("t5_one_pop", 32'(rd_a - rd_base), 32'd1);
    check("t5_cnt_after", 32'(cnt_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
